// File: rtl/gpu_mem_sequencer.sv
// rtl/gpu_mem_sequencer.sv - three-beat memory-stage sequencer with pipeline/host round-robin arbitration
module gpu_mem_sequencer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pipe_req,
  input  logic                pipe_we,
  input  logic [ADDR_W-1:0]   A1M,
  input  logic [ADDR_W-1:0]   A2M,
  input  logic [ADDR_W-1:0]   A3M,
  input  logic [3*DATA_W-1:0] writeDataM,
  output logic [3*DATA_W-1:0] RDM,
  output logic                stall,
  output logic                pipe_done,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_gnt,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_rvalid,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_PFIN,
    S_HOST,
    S_HOSTR
  } state_t;

  state_t                state_q, state_d;
  logic                  last_host_q, last_host_d;   // 1 = host held the RAM last
  logic                  pipe_we_q, pipe_we_d;
  logic                  host_we_q, host_we_d;
  logic [3*ADDR_W-1:0]   addr_q, addr_d;             // lane i address at [i*ADDR_W +: ADDR_W]
  logic [3*DATA_W-1:0]   wdata_q, wdata_d;
  logic [3*DATA_W-1:0]   rdm_q, rdm_d;
  logic [DATA_W-1:0]     host_rdata_q, host_rdata_d;
  logic                  pipe_done_q, pipe_done_d;
  logic                  host_gnt_q, host_gnt_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic                  pipe_wins;

  // Pipeline takes a tie only when the host was served last.
  assign pipe_wins = pipe_req && (!host_req || last_host_q);

  // The pipeline is frozen from the first request cycle until its final beat completes.
  assign stall = pipe_req && (state_q != S_PFIN);

  assign RDM         = rdm_q;
  assign pipe_done   = pipe_done_q;
  assign host_gnt    = host_gnt_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;

  // Next-state and next-output logic; RAM controls are set up on the edge entering each beat state.
  always_comb begin
    state_d       = state_q;
    last_host_d   = last_host_q;
    pipe_we_d     = pipe_we_q;
    host_we_d     = host_we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdm_d         = rdm_q;
    host_rdata_d  = host_rdata_q;
    pipe_done_d   = 1'b0;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (pipe_wins) begin
          state_d     = S_P0;
          last_host_d = 1'b0;
          pipe_we_d   = pipe_we;
          addr_d      = {A3M, A2M, A1M};
          wdata_d     = writeDataM;
          ram_addr_d  = A1M;
          ram_wdata_d = writeDataM[0 +: DATA_W];
          ram_we_d    = pipe_we;
        end else if (host_req) begin
          state_d     = S_HOST;
          last_host_d = 1'b1;
          host_we_d   = host_we;
          ram_addr_d  = host_addr;
          ram_wdata_d = host_wdata;
          ram_we_d    = host_we;
          host_gnt_d  = 1'b1;
        end
      end
      S_P0: begin
        state_d     = S_P1;
        ram_addr_d  = addr_q[ADDR_W +: ADDR_W];
        ram_wdata_d = wdata_q[DATA_W +: DATA_W];
        ram_we_d    = pipe_we_q;
      end
      S_P1: begin
        state_d     = S_P2;
        ram_addr_d  = addr_q[2*ADDR_W +: ADDR_W];
        ram_wdata_d = wdata_q[2*DATA_W +: DATA_W];
        ram_we_d    = pipe_we_q;
        if (!pipe_we_q) rdm_d[0 +: DATA_W] = ram_rdata;
      end
      S_P2: begin
        state_d     = S_PFIN;
        pipe_done_d = 1'b1;
        if (!pipe_we_q) rdm_d[DATA_W +: DATA_W] = ram_rdata;
      end
      S_PFIN: begin
        state_d = S_IDLE;
        if (!pipe_we_q) rdm_d[2*DATA_W +: DATA_W] = ram_rdata;
      end
      S_HOST: begin
        if (host_we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d       = S_HOSTR;
          host_rvalid_d = 1'b1;
        end
      end
      S_HOSTR: begin
        state_d      = S_IDLE;
        host_rdata_d = ram_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single state register; reset aborts any sequence and hands the first tie to the pipeline.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      last_host_q   <= 1'b1;
      pipe_we_q     <= 1'b0;
      host_we_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdm_q         <= '0;
      host_rdata_q  <= '0;
      pipe_done_q   <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_host_q   <= last_host_d;
      pipe_we_q     <= pipe_we_d;
      host_we_q     <= host_we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdm_q         <= rdm_d;
      host_rdata_q  <= host_rdata_d;
      pipe_done_q   <= pipe_done_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_gpu_mem_sequencer.sv
// tb/tb_gpu_mem_sequencer.sv - directed and randomized checks of gpu_mem_sequencer against a memory-level model
module tb_gpu_mem_sequencer;
  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          pipe_req = 1'b0;
  logic          pipe_we = 1'b0;
  logic [AW-1:0] A1M = '0, A2M = '0, A3M = '0;
  logic [3*DW-1:0] writeDataM = '0;
  logic [3*DW-1:0] RDM;
  logic          stall, pipe_done;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]   ram     [0:DEPTH-1];
  logic [DW-1:0]   ref_mem [0:DEPTH-1];
  logic            init_done = 1'b0;
  logic [3*DW-1:0] exp_rdm;
  logic [DW-1:0]   exp_hrdata;

  always #5 CLK = ~CLK;

  gpu_mem_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_req(pipe_req), .pipe_we(pipe_we),
    .A1M(A1M), .A2M(A2M), .A3M(A3M),
    .writeDataM(writeDataM), .RDM(RDM),
    .stall(stall), .pipe_done(pipe_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 100) return DW'(32'h00011);
    if (i == 101) return DW'(32'h00022);
    if (i == 102) return DW'(32'h00033);
    return DW'(i * 499 + 7);
  endfunction

  // Single-port synchronous RAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One pipeline access starting in an IDLE cycle; ends one tick after the PFIN edge.
  task automatic do_pipe(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] a3, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic hold);
    logic [AW-1:0] ad [3];
    logic [DW-1:0] dd [3];
    ad = '{a1, a2, a3};
    dd = '{d0, d1, d2};
    pipe_req   = 1'b1;
    pipe_we    = we;
    A1M        = a1;
    A2M        = a2;
    A3M        = a3;
    writeDataM = {d2, d1, d0};
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("stall_c%0d", k), stall, (k < 4));
      check($sformatf("pipe_done_c%0d", k), pipe_done, (k == 4));
      if (k >= 1 && k <= 3) begin
        check($sformatf("ram_we_beat%0d", k - 1), ram_we, we);
        check($sformatf("ram_addr_beat%0d", k - 1), ram_addr, ad[k-1]);
        if (we) check($sformatf("ram_wdata_beat%0d", k - 1), ram_wdata, dd[k-1]);
      end else begin
        check($sformatf("ram_we_off_c%0d", k), ram_we, 1'b0);
      end
      step();
      if (k == 0) begin
        A1M        = AW'($urandom);
        A2M        = AW'($urandom);
        A3M        = AW'($urandom);
        pipe_we    = 1'($urandom);
        writeDataM = (3*DW)'({$urandom, $urandom});
      end
    end
    if (we) begin
      for (int i = 0; i < 3; i++) ref_mem[ad[i]] = dd[i];
    end else begin
      exp_rdm = {ref_mem[ad[2]], ref_mem[ad[1]], ref_mem[ad[0]]};
    end
    check("RDM", RDM, exp_rdm);
    pipe_req = hold;
  endtask

  // One host access starting in an IDLE cycle; ends one tick into the following IDLE cycle.
  task automatic do_host(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    @(negedge CLK);
    check("host_gnt_idle", host_gnt, 1'b0);
    step();
    @(negedge CLK);
    check("host_gnt", host_gnt, 1'b1);
    check("host_ram_addr", ram_addr, addr);
    check("host_ram_we", ram_we, we);
    if (we) check("host_ram_wdata", ram_wdata, wdata);
    step();
    host_req  = 1'b0;
    host_addr = AW'($urandom);
    @(negedge CLK);
    check("host_gnt_after", host_gnt, 1'b0);
    check("host_rvalid", host_rvalid, !we);
    check("host_ram_we_after", ram_we, 1'b0);
    step();
    if (we) ref_mem[addr] = wdata;
    else    exp_hrdata = ref_mem[addr];
    check("host_rdata", host_rdata, exp_hrdata);
    check("RDM_hold_host", RDM, exp_rdm);
  endtask

  initial begin
    int ev[$];
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    exp_rdm    = '0;
    exp_hrdata = '0;

    // Reset state
    repeat (3) step();
    @(negedge CLK);
    check("rst_RDM", RDM, '0);
    check("rst_host_rdata", host_rdata, '0);
    check("rst_pipe_done", pipe_done, 1'b0);
    check("rst_host_gnt", host_gnt, 1'b0);
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_stall", stall, 1'b0);
    step();
    RST = 1'b1;
    step();

    // Pipeline load of the preloaded words
    do_pipe(1'b0, AW'(101), AW'(102), AW'(100), '0, '0, '0, 1'b0);
    check("load_lanes", RDM, {DW'(32'h00011), DW'(32'h00033), DW'(32'h00022)});

    // Pipeline store, then host readback per lane
    do_pipe(1'b1, AW'(5), AW'(6), AW'(4), DW'(32'h3FFFF), DW'(32'h00001), DW'(32'h12345), 1'b0);
    do_host(1'b0, AW'(5), '0);
    check("store_lane0", host_rdata, DW'(32'h3FFFF));
    do_host(1'b0, AW'(6), '0);
    check("store_lane1", host_rdata, DW'(32'h00001));
    do_host(1'b0, AW'(4), '0);
    check("store_lane2", host_rdata, DW'(32'h12345));

    // Host write then read
    do_host(1'b1, AW'(7), DW'(32'h0ABCD));
    do_host(1'b0, AW'(7), '0);
    check("host_rw", host_rdata, DW'(32'h0ABCD));

    // Simultaneous requests from reset alternate pipeline, host, pipeline, host
    RST = 1'b0;
    exp_rdm    = '0;
    exp_hrdata = '0;
    step();
    RST = 1'b1;
    pipe_req = 1'b1; pipe_we = 1'b0;
    A1M = AW'(110); A2M = AW'(111); A3M = AW'(112);
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'(7);
    for (int c = 0; c < 40 && ev.size() < 4; c++) begin
      @(negedge CLK);
      if (pipe_done) ev.push_back(1);
      if (host_gnt)  ev.push_back(2);
      step();
    end
    check("arb_event_count", ev.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_order%0d", i), (i < ev.size()) ? ev[i] : 0, (i % 2 == 0) ? 1 : 2);
    pipe_req = 1'b0;
    host_req = 1'b0;
    repeat (2) step();
    exp_rdm    = {ref_mem[112], ref_mem[111], ref_mem[110]};
    exp_hrdata = ref_mem[7];
    check("arb_RDM", RDM, exp_rdm);
    check("arb_host_rdata", host_rdata, exp_hrdata);

    // Reset during P1 of a load
    pipe_req = 1'b1; pipe_we = 1'b0;
    A1M = AW'(120); A2M = AW'(121); A3M = AW'(122);
    step();
    step();
    RST = 1'b0;
    exp_rdm    = '0;
    exp_hrdata = '0;
    @(negedge CLK);
    check("midrst_stall", stall, 1'b1);
    check("midrst_RDM", RDM, '0);
    check("midrst_pipe_done", pipe_done, 1'b0);
    check("midrst_ram_we", ram_we, 1'b0);
    check("midrst_ram_addr", ram_addr, '0);
    step();
    @(negedge CLK);
    check("midrst_pipe_done2", pipe_done, 1'b0);
    step();
    RST = 1'b1;
    do_pipe(1'b0, AW'(120), AW'(121), AW'(122), '0, '0, '0, 1'b0);

    // Back-to-back loads with pipe_req held throughout
    for (int i = 0; i < 4; i++)
      do_pipe(1'b0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
              AW'($urandom_range(0, 31)), '0, '0, '0, (i < 3));

    // Randomized mix of pipeline and host accesses over a small aliasing window
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: do_pipe(1'b0, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                   AW'($urandom_range(0, 15)), '0, '0, '0, 1'b0);
        1: do_pipe(1'b1, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                   AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
        2: do_host(1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
        default: do_host(1'b0, AW'($urandom_range(0, 15)), '0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
